// File: rtl/bellek_test_denetleyici.sv
// Memory test controller: writes a seeded incrementing pattern, reads it back and counts mismatches.
// Optional inverted second pass is built when BELLEK_TEST_TERS_GECIS_EN is defined.
module bellek_test_denetleyici #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    basla,
    input  logic [DATA_WIDTH-1:0]   tohum,
    output logic                    ram_cs,
    output logic                    ram_we,
    output logic                    ram_oe,
    output logic [ADDR_WIDTH-1:0]   ram_yaz_addr,
    output logic [ADDR_WIDTH-1:0]   ram_oku_addr,
    output logic [DATA_WIDTH-1:0]   ram_data,
    input  logic [DATA_WIDTH-1:0]   ram_oku_data,
    output logic                    mesgul,
    output logic                    bitti,
    output logic                    hata,
    output logic [ADDR_WIDTH+1:0]   hata_sayisi,
    output logic [ADDR_WIDTH-1:0]   ilk_hata_addr
);

    typedef enum logic [2:0] {
        BOSTA,
        YAZ,
        OKU,
        BOSALT,
        SON
    } durum_t;

    localparam logic [ADDR_WIDTH-1:0] SON_IDX = ADDR_WIDTH'(DEPTH - 1);

    durum_t                  durum, durum_d;
    logic [ADDR_WIDTH-1:0]   idx, idx_d;
    logic [DATA_WIDTH-1:0]   tohum_r, tohum_d;
    logic                    basla_kabul;
    logic                    son_adres;

`ifdef BELLEK_TEST_TERS_GECIS_EN
    logic                    ters, ters_d;
`else
    localparam logic         ters   = 1'b0;
    localparam logic         ters_d = 1'b0;
`endif

    logic                    cs_d, we_d, oe_d;
    logic [ADDR_WIDTH-1:0]   yaz_addr_d, oku_addr_d;
    logic [DATA_WIDTH-1:0]   data_d;

    logic                    oku_gecerli;
    logic [DATA_WIDTH-1:0]   okunan, beklenen;
    logic [ADDR_WIDTH-1:0]   oku_idx;
    logic                    uyusmazlik;

    function automatic logic [DATA_WIDTH-1:0] desen(
        input logic [DATA_WIDTH-1:0] t,
        input logic [ADDR_WIDTH-1:0] k,
        input logic                  tr
    );
        desen = (t + DATA_WIDTH'(k)) ^ {DATA_WIDTH{tr}};
    endfunction

    always_comb begin
        durum_d     = durum;
        idx_d       = idx;
        tohum_d     = tohum_r;
        basla_kabul = 1'b0;
`ifdef BELLEK_TEST_TERS_GECIS_EN
        ters_d      = ters;
`endif
        son_adres   = (idx == SON_IDX);

        case (durum)
            BOSTA, SON: begin
                if (basla) begin
                    basla_kabul = 1'b1;
                    durum_d     = YAZ;
                    idx_d       = '0;
                    tohum_d     = tohum;
`ifdef BELLEK_TEST_TERS_GECIS_EN
                    ters_d      = 1'b0;
`endif
                end
            end
            YAZ: begin
                if (son_adres) begin
                    durum_d = OKU;
                    idx_d   = '0;
                end else begin
                    idx_d = idx + 1'b1;
                end
            end
            OKU: begin
                if (son_adres) begin
                    durum_d = BOSALT;
                end else begin
                    idx_d = idx + 1'b1;
                end
            end
            BOSALT: begin
`ifdef BELLEK_TEST_TERS_GECIS_EN
                if (!ters) begin
                    durum_d = YAZ;
                    idx_d   = '0;
                    ters_d  = 1'b1;
                end else begin
                    durum_d = SON;
                end
`else
                durum_d = SON;
`endif
            end
            default: durum_d = BOSTA;
        endcase
    end

    // Bus outputs are registered from the next state so they line up with it.
    always_comb begin
        cs_d       = durum_d inside {YAZ, OKU, BOSALT};
        we_d       = (durum_d == YAZ);
        oe_d       = durum_d inside {OKU, BOSALT};
        yaz_addr_d = ram_yaz_addr;
        oku_addr_d = ram_oku_addr;
        data_d     = ram_data;
        if (durum_d == YAZ) begin
            yaz_addr_d = idx_d;
            data_d     = desen(tohum_d, idx_d, ters_d);
        end
        if (durum_d == OKU) begin
            oku_addr_d = idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            durum        <= BOSTA;
            idx          <= '0;
            tohum_r      <= '0;
`ifdef BELLEK_TEST_TERS_GECIS_EN
            ters         <= 1'b0;
`endif
            ram_cs       <= 1'b0;
            ram_we       <= 1'b0;
            ram_oe       <= 1'b0;
            ram_yaz_addr <= '0;
            ram_oku_addr <= '0;
            ram_data     <= '0;
        end else begin
            durum        <= durum_d;
            idx          <= idx_d;
            tohum_r      <= tohum_d;
`ifdef BELLEK_TEST_TERS_GECIS_EN
            ters         <= ters_d;
`endif
            ram_cs       <= cs_d;
            ram_we       <= we_d;
            ram_oe       <= oe_d;
            ram_yaz_addr <= yaz_addr_d;
            ram_oku_addr <= oku_addr_d;
            ram_data     <= data_d;
        end
    end

    // Read data for the address driven this cycle is valid at this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oku_gecerli <= 1'b0;
            okunan      <= '0;
            beklenen    <= '0;
            oku_idx     <= '0;
        end else begin
            oku_gecerli <= (durum == OKU);
            okunan      <= ram_oku_data;
            beklenen    <= desen(tohum_r, idx, ters);
            oku_idx     <= idx;
        end
    end

    assign uyusmazlik = oku_gecerli && (okunan != beklenen);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hata_sayisi   <= '0;
            ilk_hata_addr <= '0;
        end else if (basla_kabul) begin
            hata_sayisi   <= '0;
            ilk_hata_addr <= '0;
        end else if (uyusmazlik) begin
            if (!(&hata_sayisi)) begin
                hata_sayisi <= hata_sayisi + 1'b1;
            end
            if (hata_sayisi == '0) begin
                ilk_hata_addr <= oku_idx;
            end
        end
    end

    assign mesgul = durum inside {YAZ, OKU, BOSALT};
    assign bitti  = (durum == SON);
    assign hata   = (hata_sayisi != '0);

endmodule

// File: tb/tb_bellek_test_denetleyici.sv
// Randomized self-checking bench for bellek_test_denetleyici with a behavioural RAM and error model.
// Follows BELLEK_TEST_TERS_GECIS_EN to expect one or two passes.
module tb_bellek_test_denetleyici;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;
`ifdef BELLEK_TEST_TERS_GECIS_EN
    localparam int GECIS = 2;
`else
    localparam int GECIS = 1;
`endif
    localparam int BITTI_GEC = (GECIS == 2) ? 4 * DEPTH + 2 : 2 * DEPTH + 1;

    logic          clk;
    logic          rst_n;
    logic          basla;
    logic [DW-1:0] tohum;
    logic          ram_cs, ram_we, ram_oe;
    logic [AW-1:0] ram_yaz_addr, ram_oku_addr;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_oku_data;
    logic          mesgul, bitti, hata;
    logic [AW+1:0] hata_sayisi;
    logic [AW-1:0] ilk_hata_addr;

    bellek_test_denetleyici #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .basla         (basla),
        .tohum         (tohum),
        .ram_cs        (ram_cs),
        .ram_we        (ram_we),
        .ram_oe        (ram_oe),
        .ram_yaz_addr  (ram_yaz_addr),
        .ram_oku_addr  (ram_oku_addr),
        .ram_data      (ram_data),
        .ram_oku_data  (ram_oku_data),
        .mesgul        (mesgul),
        .bitti         (bitti),
        .hata          (hata),
        .hata_sayisi   (hata_sayisi),
        .ilk_hata_addr (ilk_hata_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int kontrol_say = 0;
    int hata_say    = 0;

    task automatic kontrol(input string tag, input logic [31:0] gozlenen,
                           input logic [31:0] beklenen);
        kontrol_say++;
        if (gozlenen !== beklenen) begin
            hata_say++;
            $display("FAIL %s: gozlenen=%0h beklenen=%0h", tag, gozlenen, beklenen);
        end
    endtask

    function automatic logic [DW-1:0] desen(input logic [DW-1:0] t, input int k,
                                            input int tr);
        logic [DW-1:0] v;
        v = t + DW'(k);
        return (tr != 0) ? ~v : v;
    endfunction

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd;
    int            yazma_say;
    int            okuma_gecis;
    int            h_addr;
    logic [DW-1:0] h_maske;
    int            h_gecis;
    logic [DW-1:0] run_tohum;

    assign ram_oku_data = rd;

    // Falling-edge RAM with an optional stuck-at-1 mask on one address in one pass.
    always @(negedge clk) begin
        if (ram_cs && ram_we) begin
            kontrol("yaz", {ram_yaz_addr, ram_data},
                    {AW'(yazma_say % DEPTH),
                     desen(run_tohum, yazma_say % DEPTH, yazma_say / DEPTH)});
            mem[ram_yaz_addr] = ram_data;
            yazma_say++;
        end
        if (ram_cs && ram_oe) begin
            if (ram_oku_addr == '0) okuma_gecis++;
            rd = mem[ram_oku_addr];
            if (int'(ram_oku_addr) == h_addr && okuma_gecis - 1 == h_gecis)
                rd = rd | h_maske;
        end
    end

    task automatic model(output int say, output int ilk);
        logic [DW-1:0] v;
        say = 0;
        ilk = -1;
        for (int p = 0; p < GECIS; p++) begin
            for (int k = 0; k < DEPTH; k++) begin
                v = desen(run_tohum, k, p);
                if (k == h_addr && p == h_gecis && (v | h_maske) != v) begin
                    say++;
                    if (ilk < 0) ilk = k;
                end
            end
        end
        if (say > (1 << (AW + 2)) - 1) say = (1 << (AW + 2)) - 1;
    endtask

    task automatic baslat(input logic [DW-1:0] t, input int fa,
                          input logic [DW-1:0] fm, input int fg);
        run_tohum   = t;
        h_addr      = fa;
        h_maske     = fm;
        h_gecis     = fg;
        yazma_say   = 0;
        okuma_gecis = 0;
        @(negedge clk);
        tohum = t;
        basla = 1'b1;
        @(posedge clk);
        #1 basla = 1'b0;
    endtask

    task automatic kos(input logic [DW-1:0] t, input int fa, input logic [DW-1:0] fm,
                       input int fg, input int yoksay);
        int n;
        int bek_say;
        int bek_ilk;
        baslat(t, fa, fm, fg);
        kontrol("mesgul_kos", mesgul, 1);
        n = 0;
        while (!bitti && n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (n == yoksay) begin
                basla = 1'b1;
                tohum = ~t;
            end else begin
                basla = 1'b0;
            end
        end
        basla = 1'b0;
        kontrol("bitti_kenar", n, BITTI_GEC);
        kontrol("yazma_say", yazma_say, GECIS * DEPTH);
        kontrol("son_cs", {mesgul, ram_cs, ram_we, ram_oe}, 0);
        model(bek_say, bek_ilk);
        kontrol("hata_sayisi", hata_sayisi, bek_say);
        kontrol("hata", hata, (bek_say != 0));
        if (bek_say != 0) kontrol("ilk_hata", ilk_hata_addr, bek_ilk);
        repeat (3) @(posedge clk);
        #1 kontrol("bitti_tut", bitti, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL zaman_asimi: gozlenen=asim beklenen=bitis");
        $fatal(1, "zaman asimi");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        rd      = '0;
        rst_n   = 1'b0;
        basla   = 1'b0;
        tohum   = '0;
        h_addr  = -1;
        h_maske = '0;
        h_gecis = 0;
        repeat (3) @(posedge clk);
        #1;
        kontrol("rst_bus", {ram_cs, ram_we, ram_oe, ram_yaz_addr, ram_oku_addr, ram_data}, 0);
        kontrol("rst_durum", {mesgul, bitti, hata, hata_sayisi, ilk_hata_addr}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        kos(16'h1234, -1, '0, 0, 0);
        kos(16'hFFFF, -1, '0, 0, 0);
`ifdef BELLEK_TEST_TERS_GECIS_EN
        kontrol("sarma_0", mem[0], 16'h0000);
        kontrol("sarma_3", mem[3], 16'hFFFD);
`else
        kontrol("sarma_0", mem[0], 16'hFFFF);
        kontrol("sarma_3", mem[3], 16'h0002);
`endif
        kos(16'h0001, 5, 16'h0001, 0, 0);
        kos(16'h4321, -1, '0, 0, 19);

        baslat(16'h0000, 2, 16'h0001, 0);
        repeat (23) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        kontrol("orta_rst_bus", {mesgul, ram_cs, ram_we, ram_oe}, 0);
        kontrol("orta_rst_hata", {bitti, hata, hata_sayisi, ilk_hata_addr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        kos(16'h0ABC, -1, '0, 0, 0);

`ifdef BELLEK_TEST_TERS_GECIS_EN
        kos(16'h0000, 2, 16'h0002, 1, 0);
        kontrol("ters_5", mem[5], 16'hFFFA);
`endif

        for (int r = 0; r < 6; r++) begin
            kos(DW'($urandom), int'($urandom_range(0, DEPTH - 1)),
                DW'(1) << $urandom_range(0, DW - 1),
                int'($urandom_range(0, GECIS - 1)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", kontrol_say, hata_say);
        $finish;
    end

endmodule
